// File: rtl/mem_resp_pkg.sv
// Shared types, widths and frame-building helpers for the memory-response UART transmitter.
// MEM_RESP_TX_CHECKSUM_EN adds the frame checksum helper.
package mem_resp_pkg;

    localparam int RESP_W           = 42;
    localparam int ADDR_W           = 9;
    localparam int DATA_W           = 32;
    localparam int FRAME_BYTES_BASE = 6;

    localparam logic SRC_IMEM = 1'b0;
    localparam logic SRC_DMEM = 1'b1;

    localparam int RESP_VALID_BIT   = 41;
    localparam int RESP_ADDR_LSB    = 32;
    localparam int HDR_VALID_BIT    = 7;
    localparam int HDR_SRC_BIT      = 6;
    localparam int HDR_ADDR_MSB_BIT = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4,
        NEXT  = 3'd5
    } tx_state_e;

    function automatic logic [7:0] frame_header(input logic [RESP_W-1:0] resp, input logic src);
        logic [7:0] hdr;
        hdr                   = 8'h00;
        hdr[HDR_VALID_BIT]    = resp[RESP_VALID_BIT];
        hdr[HDR_SRC_BIT]      = src;
        hdr[HDR_ADDR_MSB_BIT] = resp[RESP_ADDR_LSB+ADDR_W-1];
        return hdr;
    endfunction

    // B0..B5, B0 in the most significant byte so the frame shifts out from the top.
    function automatic logic [FRAME_BYTES_BASE*8-1:0] build_frame(input logic [RESP_W-1:0] resp,
                                                                  input logic src);
        return {frame_header(resp, src), resp[RESP_ADDR_LSB+7:RESP_ADDR_LSB], resp[DATA_W-1:0]};
    endfunction

`ifdef MEM_RESP_TX_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [FRAME_BYTES_BASE*8-1:0] bytes);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < FRAME_BYTES_BASE; i++) begin
            acc = acc ^ bytes[i*8 +: 8];
        end
        return acc;
    endfunction
`endif

endpackage

// File: rtl/mem_resp_uart_tx_byte.sv
// Single-byte 8N1 serialiser: start pulse loads a byte, done pulses in the last stop-bit cycle.
module uart_tx_byte
    import mem_resp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    tx_state_e         state_r;
    tx_state_e         state_nxt_s;
    logic [BAUD_W-1:0] baud_r;
    logic [BAUD_W-1:0] baud_nxt_s;
    logic [2:0]        bit_r;
    logic [2:0]        bit_nxt_s;
    logic [7:0]        shreg_r;
    logic              tx_r;
    logic              tx_nxt_s;
    logic              baud_last_s;

    assign baud_last_s = (baud_r == BAUD_W'(CLKS_PER_BIT - 1));
    assign tx          = tx_r;

    // Next state, bit index, baud count and line level.
    always_comb begin
        state_nxt_s = state_r;
        done        = 1'b0;
        case (state_r)
            IDLE:    if (start) state_nxt_s = START; else state_nxt_s = IDLE;
            START:   if (baud_last_s) state_nxt_s = DATA; else state_nxt_s = START;
            DATA:    if (baud_last_s && (bit_r == 3'd7)) state_nxt_s = STOP; else state_nxt_s = DATA;
            STOP: begin
                if (baud_last_s) begin
                    state_nxt_s = IDLE;
                    done        = 1'b1;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase

        if (state_nxt_s != DATA)  bit_nxt_s = 3'd0;
        else if (state_r != DATA) bit_nxt_s = 3'd0;
        else if (baud_last_s)     bit_nxt_s = bit_r + 3'd1;
        else                      bit_nxt_s = bit_r;

        // The counter restarts on every state entry and wraps once per bit period.
        if ((state_nxt_s != state_r) || (state_r == IDLE) || baud_last_s) baud_nxt_s = '0;
        else                                                              baud_nxt_s = baud_r + BAUD_W'(1);

        case (state_nxt_s)
            START:   tx_nxt_s = 1'b0;
            DATA:    tx_nxt_s = shreg_r[bit_nxt_s];
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // Serialiser registers; line is forced idle-high by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            baud_r  <= '0;
            bit_r   <= 3'd0;
            shreg_r <= 8'h00;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            baud_r  <= baud_nxt_s;
            bit_r   <= bit_nxt_s;
            tx_r    <= tx_nxt_s;
            if ((state_r == IDLE) && start) shreg_r <= data;
            else                            shreg_r <= shreg_r;
        end
    end

endmodule

// File: rtl/mem_resp_uart_tx.sv
// Memory-response UART transmitter top: two pending slots, imem-first arbiter, frame sequencing.
// Optional MEM_RESP_TX_CHECKSUM_EN appends an XOR checksum byte to each frame.
module mem_resp_uart_tx
    import mem_resp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FRAME_BYTES  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              imem_resp_ready,
    input  logic [RESP_W-1:0] imem_resp_data,
    input  logic              dmem_resp_ready,
    input  logic [RESP_W-1:0] dmem_resp_data,
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              resp_overflow,
    input  logic              clr_overflow
);

`ifdef MEM_RESP_TX_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_BYTES + 1;
`else
    localparam int FRAME_LEN = FRAME_BYTES;
`endif
    localparam int FRAME_W = FRAME_LEN * 8;
    localparam int IDX_W   = $clog2(FRAME_LEN + 1);

    tx_state_e         state_r;
    tx_state_e         state_nxt_s;
    logic [RESP_W-1:0] imem_slot_r;
    logic [RESP_W-1:0] dmem_slot_r;
    logic              imem_full_r;
    logic              dmem_full_r;
    logic              imem_full_nxt_s;
    logic              dmem_full_nxt_s;
    logic              imem_drain_s;
    logic              dmem_drain_s;
    logic              imem_take_s;
    logic              dmem_take_s;
    logic              ovf_set_s;
    logic [FRAME_W-1:0] frame_r;
    logic [FRAME_W-1:0] frame_fill_s;
    logic [IDX_W-1:0]  idx_r;
    logic              byte_start_s;
    logic              byte_done_s;
    logic              tx_busy_r;
    logic              resp_overflow_r;

    assign tx_busy       = tx_busy_r;
    assign resp_overflow = resp_overflow_r;

    // Slot occupancy: a strobe on the drain edge refills rather than overflows.
    always_comb begin
        imem_drain_s = (state_r == IDLE) & imem_full_r;
        dmem_drain_s = (state_r == IDLE) & ~imem_full_r & dmem_full_r;
        imem_take_s  = imem_resp_ready & (~imem_full_r | imem_drain_s);
        dmem_take_s  = dmem_resp_ready & (~dmem_full_r | dmem_drain_s);
        ovf_set_s    = (imem_resp_ready & imem_full_r & ~imem_drain_s) |
                       (dmem_resp_ready & dmem_full_r & ~dmem_drain_s);

        if (imem_resp_ready)   imem_full_nxt_s = 1'b1;
        else if (imem_drain_s) imem_full_nxt_s = 1'b0;
        else                   imem_full_nxt_s = imem_full_r;

        if (dmem_resp_ready)   dmem_full_nxt_s = 1'b1;
        else if (dmem_drain_s) dmem_full_nxt_s = 1'b0;
        else                   dmem_full_nxt_s = dmem_full_r;

`ifdef MEM_RESP_TX_CHECKSUM_EN
        if (imem_drain_s) frame_fill_s = {build_frame(imem_slot_r, SRC_IMEM), 8'h00};
        else              frame_fill_s = {build_frame(dmem_slot_r, SRC_DMEM), 8'h00};
`else
        if (imem_drain_s) frame_fill_s = build_frame(imem_slot_r, SRC_IMEM);
        else              frame_fill_s = build_frame(dmem_slot_r, SRC_DMEM);
`endif
    end

    // Frame sequencing; START here spans the whole byte the serialiser is sending.
    always_comb begin
        state_nxt_s  = state_r;
        byte_start_s = 1'b0;
        case (state_r)
            IDLE:  if (imem_full_r | dmem_full_r) state_nxt_s = LOAD; else state_nxt_s = IDLE;
            LOAD: begin
                state_nxt_s  = START;
                byte_start_s = 1'b1;
            end
            START: if (byte_done_s) state_nxt_s = NEXT; else state_nxt_s = START;
            NEXT: begin
                if (idx_r == IDX_W'(FRAME_LEN - 1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s  = START;
                    byte_start_s = 1'b1;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pending slots, overflow flag and registered busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_slot_r     <= '0;
            dmem_slot_r     <= '0;
            imem_full_r     <= 1'b0;
            dmem_full_r     <= 1'b0;
            resp_overflow_r <= 1'b0;
            tx_busy_r       <= 1'b0;
        end else begin
            if (imem_take_s) imem_slot_r <= imem_resp_data;
            else             imem_slot_r <= imem_slot_r;
            if (dmem_take_s) dmem_slot_r <= dmem_resp_data;
            else             dmem_slot_r <= dmem_slot_r;
            imem_full_r <= imem_full_nxt_s;
            dmem_full_r <= dmem_full_nxt_s;
            if (ovf_set_s)         resp_overflow_r <= 1'b1;
            else if (clr_overflow) resp_overflow_r <= 1'b0;
            else                   resp_overflow_r <= resp_overflow_r;
            tx_busy_r <= (state_nxt_s != IDLE) | imem_full_nxt_s | dmem_full_nxt_s;
        end
    end

    // FSM state, byte index and frame shift register (B0 always sits in the top byte).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            frame_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == IDLE)                              idx_r <= '0;
            else if ((state_r == NEXT) && (state_nxt_s == START)) idx_r <= idx_r + IDX_W'(1);
            else                                              idx_r <= idx_r;

            if (imem_drain_s | dmem_drain_s) frame_r <= frame_fill_s;
`ifdef MEM_RESP_TX_CHECKSUM_EN
            else if (state_r == LOAD)        frame_r[7:0] <= xor_bytes(frame_r[FRAME_W-1:8]);
`endif
            else if (byte_done_s)            frame_r <= frame_r << 8;
            else                             frame_r <= frame_r;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (byte_start_s),
        .data    (frame_r[FRAME_W-1 -: 8]),
        .tx      (uart_tx),
        .done    (byte_done_s)
    );

endmodule

// File: tb/tb_mem_resp_uart_tx.sv
// Self-checking bench for mem_resp_uart_tx: table of single/dual responses plus overflow,
// drain-edge refill and mid-frame reset sequences. Honours MEM_RESP_TX_CHECKSUM_EN.
module tb_mem_resp_uart_tx;

    localparam int CPB = 4;
`ifdef MEM_RESP_TX_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_resp_ready = 1'b0;
    logic [41:0] imem_resp_data = 42'h0;
    logic        dmem_resp_ready = 1'b0;
    logic [41:0] dmem_resp_data = 42'h0;
    logic        clr_overflow = 1'b0;
    logic        uart_tx;
    logic        tx_busy;
    logic        resp_overflow;

    int checks   = 0;
    int failures = 0;

    mem_resp_uart_tx #(.CLKS_PER_BIT(CPB), .FRAME_BYTES(6)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_resp_ready (imem_resp_ready),
        .imem_resp_data  (imem_resp_data),
        .dmem_resp_ready (dmem_resp_ready),
        .dmem_resp_data  (dmem_resp_data),
        .uart_tx         (uart_tx),
        .tx_busy         (tx_busy),
        .resp_overflow   (resp_overflow),
        .clr_overflow    (clr_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        im;
        logic [41:0] id;
        logic        dm;
        logic [41:0] dd;
        logic [47:0] f0;
        logic [47:0] f1;
        int          nf;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [47:0] f, input int i);
        logic [7:0] c;
        if (i < 6) return f[47-8*i -: 8];
        c = 8'h00;
        for (int k = 0; k < 6; k++) c = c ^ f[47-8*k -: 8];
        return c;
    endfunction

    task automatic recv_byte(input int limit, output logic [7:0] b, output int waited);
        waited = 0;
        b      = 8'h00;
        do begin
            @(negedge clk);
            waited++;
        end while (uart_tx !== 1'b0 && waited < limit);
        if (uart_tx !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL start_timeout: no start bit after %0d cycles, required within %0d", waited, limit);
            waited = -1;
        end else begin
            repeat (2) @(negedge clk);
            check("start_bit", {63'd0, uart_tx}, 64'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            check("stop_bit", {63'd0, uart_tx}, 64'd1);
        end
    endtask

    task automatic recv_frame(input string tag, input logic [47:0] f, input int first_limit,
                              input int first_wait);
        logic [7:0] b;
        int         w;
        for (int i = 0; i < NB; i++) begin
            recv_byte((i == 0) ? first_limit : 10, b, w);
            if (i == 0) begin
                if (first_wait >= 0) check({tag, "_lead"}, 64'(w), 64'(first_wait));
            end else begin
                check({tag, "_gap"}, 64'(w), 64'd3);
            end
            check($sformatf("%s_b%0d", tag, i), {56'd0, b}, {56'd0, exp_byte(f, i)});
        end
    endtask

    task automatic strobe(input logic im, input logic [41:0] id, input logic dm, input logic [41:0] dd);
        imem_resp_ready = im;
        imem_resp_data  = id;
        dmem_resp_ready = dm;
        dmem_resp_data  = dd;
        @(negedge clk);
        imem_resp_ready = 1'b0;
        dmem_resp_ready = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", {63'd0, tx_busy}, 64'd0);
    endtask

    initial begin
        logic [7:0] b;
        int         w;
        int         lows;
        int         busys;

        vecs[0] = '{1'b1, 42'h3FF_DEAD_BEEF, 1'b0, 42'h0, 48'h81FF_DEAD_BEEF, 48'h0, 1};
        vecs[1] = '{1'b1, {1'b1, 9'h005, 32'h1234_5678}, 1'b1, {1'b1, 9'h105, 32'hCAFE_F00D},
                    48'h8005_1234_5678, 48'hC105_CAFE_F00D, 2};
        vecs[2] = '{1'b0, 42'h0, 1'b1, {1'b0, 9'h0AA, 32'h0000_0000}, 48'h40AA_0000_0000, 48'h0, 1};
        vecs[3] = '{1'b1, {1'b0, 9'h100, 32'hA5A5_5A5A}, 1'b0, 42'h0, 48'h0100_A5A5_5A5A, 48'h0, 1};
        vecs[4] = '{1'b1, {1'b1, 9'h000, 32'h0000_0001}, 1'b0, 42'h0, 48'h8000_0000_0001, 48'h0, 1};

        repeat (3) @(negedge clk);
        check("rst_uart_tx", {63'd0, uart_tx}, 64'd1);
        check("rst_tx_busy", {63'd0, tx_busy}, 64'd0);
        check("rst_overflow", {63'd0, resp_overflow}, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_uart_tx", {63'd0, uart_tx}, 64'd1);

        for (int v = 0; v < 5; v++) begin
            wait_idle(2000);
            strobe(vecs[v].im, vecs[v].id, vecs[v].dm, vecs[v].dd);
            recv_frame($sformatf("v%0d_f0", v), vecs[v].f0, 20, 2);
            if (vecs[v].nf == 2) recv_frame($sformatf("v%0d_f1", v), vecs[v].f1, 20, 5);
            if (v == 0) begin
                repeat (2) @(negedge clk);
                check("busy_after_stop", {63'd0, tx_busy}, 64'd1);
                @(negedge clk);
                check("busy_falls", {63'd0, tx_busy}, 64'd0);
            end
            check($sformatf("v%0d_no_overflow", v), {63'd0, resp_overflow}, 64'd0);
        end

        // Overflow: second strobe kept, third dropped (with clr asserted in the same cycle).
        wait_idle(2000);
        strobe(1'b1, {1'b1, 9'h011, 32'h0000_AAAA}, 1'b0, 42'h0);
        fork
            begin
                recv_frame("ovf_a", 48'h8011_0000_AAAA, 20, 2);
                recv_frame("ovf_b", 48'h8022_0000_BBBB, 20, 5);
            end
            begin
                repeat (20) @(negedge clk);
                strobe(1'b1, {1'b1, 9'h022, 32'h0000_BBBB}, 1'b0, 42'h0);
                check("ovf_after_keep", {63'd0, resp_overflow}, 64'd0);
                repeat (3) @(negedge clk);
                clr_overflow = 1'b1;
                strobe(1'b1, {1'b1, 9'h033, 32'h0000_CCCC}, 1'b0, 42'h0);
                clr_overflow = 1'b0;
                check("ovf_set_wins", {63'd0, resp_overflow}, 64'd1);
            end
        join
        wait_idle(200);
        check("ovf_sticky", {63'd0, resp_overflow}, 64'd1);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("ovf_no_third_frame", 64'(lows), 64'd0);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("ovf_cleared", {63'd0, resp_overflow}, 64'd0);

        // Strobe landing on the drain edge refills the slot.
        imem_resp_ready = 1'b1;
        imem_resp_data  = {1'b1, 9'h003, 32'h1111_1111};
        @(negedge clk);
        imem_resp_data  = {1'b1, 9'h104, 32'h2222_2222};
        @(negedge clk);
        imem_resp_ready = 1'b0;
        recv_frame("refill_a", 48'h8003_1111_1111, 20, 1);
        recv_frame("refill_b", 48'h8104_2222_2222, 20, 5);
        wait_idle(200);
        check("refill_no_overflow", {63'd0, resp_overflow}, 64'd0);

        // Reset in the middle of byte 3 (0xAD): line must go high without a clock edge.
        strobe(vecs[0].im, vecs[0].id, 1'b0, 42'h0);
        for (int i = 0; i < 3; i++) begin
            recv_byte(20, b, w);
            check($sformatf("rst_seq_b%0d", i), {56'd0, b}, {56'd0, exp_byte(vecs[0].f0, i)});
        end
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (uart_tx !== 1'b0 && w < 10);
        repeat (2 + 2 * CPB) @(negedge clk);
        check("rst_pre_low", {63'd0, uart_tx}, 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_line", {63'd0, uart_tx}, 64'd1);
        check("rst_async_busy", {63'd0, tx_busy}, 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
            if (tx_busy !== 1'b0) busys++;
        end
        check("rst_no_resume_line", 64'(lows), 64'd0);
        check("rst_no_resume_busy", 64'(busys), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_resp_uart_tx.md
Name: mem_resp_uart_tx

Overview:
- Transmit end of the UART debug memory-access path.
- Captures 42-bit read-response words pulsed out by the instruction memory and the data memory: {valid, addr[8:0], data[31:0]} plus a one-cycle ready strobe.
- Serialises each response as a fixed byte frame on the UART TX pin, 8N1, LSB first.
- Sits beside the UART RX command parser; one instance serves both memories.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (≥2).
- FRAME_BYTES, 6, bytes per response frame, excluding the optional checksum; fixed at 6.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- imem_resp_ready  in  1  one-cycle strobe; instruction-memory response valid
- imem_resp_data  in  42  {valid, addr[8:0], data[31:0]} from instruction memory
- dmem_resp_ready  in  1  one-cycle strobe; data-memory response valid
- dmem_resp_data  in  42  same format, from data memory
- uart_tx  out  1  serial line, idle high
- tx_busy  out  1  high while a frame is in flight or a response is pending
- resp_overflow  out  1  sticky; a response was dropped
- clr_overflow  in  1  synchronous clear of resp_overflow

Behaviour:
- Reset (async, reset_n=0), all outputs: uart_tx=1, tx_busy=0, resp_overflow=0; both pending slots empty; FSM in IDLE; counters at 0.
- Capture: each source has one pending slot (42 bits + full flag).
  - On the rising edge with *_resp_ready=1: data is latched and full is set.
  - Capture ignores *_resp_data[41]; the frame transmits it verbatim.
- Overflow: a strobe arriving while that slot is full, and not being drained in the same cycle:
  - the new word is dropped;
  - resp_overflow is set.
  - If clr_overflow and an overflow occur in the same cycle, set wins.
- Arbitration in IDLE: imem slot first, then dmem. The selected slot is cleared on the load edge.
  - If a strobe for the slot being drained arrives on that same edge, it refills the slot; this is not an overflow.
- Frame bytes:
  - B0 = {resp[41], src, 5'b0, addr[8]}; src=0 for imem, 1 for dmem.
  - B1 = addr[7:0].
  - B2..B5 = data[31:24], [23:16], [15:8], [7:0].
- FSM states:
  - IDLE: any slot full → LOAD.
  - LOAD: frame register filled, byte index=0 → START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles → STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles → NEXT.
  - NEXT: more bytes remain → index+1, START; last byte → IDLE.
- Timing:
  - Strobe at edge N: IDLE→LOAD at N+1; uart_tx falls at edge N+2.
  - A frame occupies 6×10×CLKS_PER_BIT cycles plus 1 cycle per NEXT.
  - Back-to-back frames: IDLE for 1 cycle between frames.
- Baud counter:
  - counts 0..CLKS_PER_BIT-1 and wraps;
  - reloads to 0 on every state entry;
  - bit counter 0..7; byte index 0..FRAME_BYTES-1 (or FRAME_BYTES with checksum).
- tx_busy = (state≠IDLE) | imem_full | dmem_full.
- Reset mid-frame: line returns high immediately and the partial frame is abandoned; nothing resumes.

Optional Feature:
- Macro MEM_RESP_TX_CHECKSUM_EN.
- Defined: a 7th byte is appended, equal to the XOR of B0..B5.
  - It is computed at LOAD.
  - Frame length becomes 7×10×CLKS_PER_BIT cycles plus 1 cycle per NEXT.
- Undefined: 6-byte frame only; no checksum logic is present.

Decomposition:
- Package mem_resp_pkg:
  - state enum (IDLE, LOAD, START, DATA, STOP, NEXT);
  - RESP_W=42, ADDR_W=9, DATA_W=32;
  - SRC_IMEM=0, SRC_DMEM=1;
  - header bit positions;
  - FRAME_BYTES_BASE=6.
- Sub-module uart_tx_byte: one 8N1 byte serialiser with a start/done handshake and the baud counter.
- The top holds the pending slots, arbiter, frame register and byte sequencing.

Test Plan (CLKS_PER_BIT=4):
- imem strobe with 42'h3_FF_DEADBEEF → bytes 0x81, 0xFF, 0xDE, 0xAD, 0xBE, 0xEF; start bit falls 2 cycles after the strobe; each bit 4 cycles; tx_busy falls after the last stop bit.
- imem and dmem strobe in the same cycle, addr 0x005 and 0x105 → imem frame first (B0=0x80, B1=0x05), then dmem frame (B0=0xC1, B1=0x05); 1 idle cycle between; no overflow.
- Three imem strobes while the first frame is in flight → second kept, third dropped, resp_overflow=1; only 2 frames appear; clr_overflow pulse → 0.
- reset_n low during DATA of byte 3 → uart_tx=1 within the same cycle (async); after release no frame is sent; tx_busy=0.
- Strobe for the slot on the exact drain edge → both words transmitted, resp_overflow stays 0.
- With MEM_RESP_TX_CHECKSUM_EN, data 0x00000001, addr 0, header 0x80 → 7th byte 0x81.
